// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_pkg                                                |
// | Brief   : Shared defaults and types for the scoreboarded reg file    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int ZERO_REG = 0;

   typedef logic [$clog2(NREGS)-1:0] reg_addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_scoreboard                                         |
// | Brief   : Per-register busy bits tracking in-flight destination      |
// |           writes; set on issue, cleared on writeback, flushable.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = regfile_pkg::NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] q1_addr,
   input  logic [AW-1:0] q2_addr,
   output logic          q1_busy,
   output logic          q2_busy
);

   localparam logic [NREGS-1:0] c_one  = NREGS'(1);
   localparam logic [AW-1:0]    c_zero = AW'(ZERO_REG);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_clr;

   // One-hot set/clear masks; register 0 is excluded so its bit never rises
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (set_en && (set_addr != c_zero)) begin
         w_set = c_one << set_addr;
      end
      if (clr_en && (clr_addr != c_zero)) begin
         w_clr = c_one << clr_addr;
      end
   end

   // Busy state: reset/flush clear everything; set is applied after clear so a new producer wins
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign q1_busy = r_busy[q1_addr];
   assign q2_busy = r_busy[q2_addr];

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_sb                                                 |
// | Brief   : Parametrised register file with same-cycle write-to-read   |
// |           bypass and a busy scoreboard for RAW hazard detection.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN    = regfile_pkg::XLEN,
   parameter int NREGS   = regfile_pkg::NREGS,
   parameter int BYPASS  = 1,
   parameter int DBG_IDX = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [$clog2(NREGS)-1:0] rs1,
   input  logic [$clog2(NREGS)-1:0] rs2,
   output logic [XLEN-1:0]          rd1,
   output logic [XLEN-1:0]          rd2,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic                     issue_valid,
   input  logic [$clog2(NREGS)-1:0] issue_rd,
   input  logic                     flush,
   output logic [XLEN-1:0]          dbg_reg
);

   localparam int            AW         = $clog2(NREGS);
   localparam logic [AW-1:0] c_zero     = AW'(ZERO_REG);
   localparam logic [AW-1:0] c_dbg_idx  = AW'(DBG_IDX);
   localparam logic          c_bypass   = (BYPASS != 0);

   logic [XLEN-1:0] r_regs [NREGS];
   logic            w_wr_en;
   logic            w_byp1;
   logic            w_byp2;
   logic            w_sb_busy1;
   logic            w_sb_busy2;

   assign w_wr_en = we && (waddr != c_zero);

   // Architectural state: reset wipes every entry; writes to register 0 are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[waddr] <= wdata;
      end
   end

   // Forwarding applies only to a live, non-zero write that matches the read address
   always_comb begin
      w_byp1 = c_bypass && w_wr_en && (waddr == rs1);
      w_byp2 = c_bypass && w_wr_en && (waddr == rs2);
   end

   // Read ports: register 0 is hardwired to zero, then bypass, then stored value
   always_comb begin
      rd1 = r_regs[rs1];
      rd2 = r_regs[rs2];
      if (rs1 == c_zero) begin
         rd1 = '0;
      end else if (w_byp1) begin
         rd1 = wdata;
      end
      if (rs2 == c_zero) begin
         rd2 = '0;
      end else if (w_byp2) begin
         rd2 = wdata;
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .set_en   (issue_valid),
      .set_addr (issue_rd),
      .clr_en   (we),
      .clr_addr (waddr),
      .q1_addr  (rs1),
      .q2_addr  (rs2),
      .q1_busy  (w_sb_busy1),
      .q2_busy  (w_sb_busy2)
   );

   // A forwarded operand is available now, so its pending write no longer stalls decode
   always_comb begin
      rs1_busy = w_sb_busy1 && !w_byp1;
      rs2_busy = w_sb_busy2 && !w_byp2;
   end

   assign dbg_reg = r_regs[c_dbg_idx];

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_regfile_sb                                              |
// | Brief   : Scoreboard bench for regfile_sb; a bypassing and a         |
// |           non-bypassing instance share the same stimulus.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_regfile_sb;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   reg_addr_t   rs1, rs2, waddr, issue_rd;
   logic        we, issue_valid, flush;
   logic [31:0] wdata;

   logic [31:0] rd1, rd2, dbg_reg;
   logic        rs1_busy, rs2_busy;
   logic [31:0] nb_rd1, nb_rd2, nb_dbg;
   logic        nb_busy1, nb_busy2;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        b1;
      logic        b2;
      logic [31:0] dbg;
      logic [31:0] rd1nb;
      logic        b1nb;
   } exp_t;

   exp_t q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1), .DBG_IDX(5)) dut (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .we(we), .waddr(waddr),
      .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .flush(flush), .dbg_reg(dbg_reg)
   );

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0), .DBG_IDX(5)) dut_nb (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd1(nb_rd1), .rd2(nb_rd2),
      .rs1_busy(nb_busy1), .rs2_busy(nb_busy2), .we(we), .waddr(waddr),
      .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .flush(flush), .dbg_reg(nb_dbg)
   );

   task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL vec%0d %s: got %h expected %h", v, name, act, exp);
      end
   endtask

   // Monitor: outputs settle mid-cycle; pop the expectation for this cycle and compare
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("rd1",       vectors, rd1,             e.rd1);
         chk("rd2",       vectors, rd2,             e.rd2);
         chk("rs1_busy",  vectors, {31'd0, rs1_busy}, {31'd0, e.b1});
         chk("rs2_busy",  vectors, {31'd0, rs2_busy}, {31'd0, e.b2});
         chk("dbg_reg",   vectors, dbg_reg,         e.dbg);
         chk("nb_rd1",    vectors, nb_rd1,          e.rd1nb);
         chk("nb_busy1",  vectors, {31'd0, nb_busy1}, {31'd0, e.b1nb});
         vectors++;
      end
   end

   task automatic step(
      input logic rst_i, input logic we_i, input reg_addr_t wa, input logic [31:0] wd,
      input logic iv, input reg_addr_t ird, input logic fl, input reg_addr_t a1, input reg_addr_t a2,
      input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic e_b1, input logic e_b2,
      input logic [31:0] e_dbg, input logic [31:0] e_rd1nb, input logic e_b1nb);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst_i; we = we_i; waddr = wa; wdata = wd;
      issue_valid = iv; issue_rd = ird; flush = fl; rs1 = a1; rs2 = a2;
      e.rd1 = e_rd1; e.rd2 = e_rd2; e.b1 = e_b1; e.b2 = e_b2;
      e.dbg = e_dbg; e.rd1nb = e_rd1nb; e.b1nb = e_b1nb;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; rs1 = '0; rs2 = '0;
      //   rst  we   wa     wdata         iv   ird    fl   rs1    rs2  | rd1           rd2           b1   b2   dbg          rd1nb         b1nb
      step(1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 5'd31, 32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd1, 5'd5,  32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      // write to x0 is neither bypassed nor stored
      step(1'b0,1'b1,5'd0, 32'hDEADBEEF, 1'b0,5'd0, 1'b0,5'd0, 5'd0,  32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 5'd31, 32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      // bypass x7 in the write cycle; non-bypass instance shows the old value
      step(1'b0,1'b1,5'd7, 32'h12345678, 1'b0,5'd0, 1'b0,5'd7, 5'd7,  32'h12345678, 32'h12345678, 1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd7, 5'd0,  32'h12345678, 32'h0,        1'b0,1'b0,32'h0,       32'h12345678, 1'b0);
      // issue rd=3: busy only from the next cycle
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b0,5'd3, 5'd3,  32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd3, 5'd3,  32'h0,        32'h0,        1'b1,1'b1,32'h0,       32'h0,        1'b1);
      // writeback x3: forwarded data masks busy
      step(1'b0,1'b1,5'd3, 32'hA5,       1'b0,5'd0, 1'b0,5'd3, 5'd3,  32'hA5,       32'hA5,       1'b0,1'b0,32'h0,       32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd3, 5'd3,  32'hA5,       32'hA5,       1'b0,1'b0,32'h0,       32'hA5,       1'b0);
      // issue and write x4 together: set wins
      step(1'b0,1'b1,5'd4, 32'h55,       1'b1,5'd4, 1'b0,5'd4, 5'd4,  32'h55,       32'h55,       1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd4, 5'd4,  32'h55,       32'h55,       1'b1,1'b1,32'h0,       32'h55,       1'b1);
      // issue 9 then 10, then flush
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b0,5'd4, 5'd9,  32'h55,       32'h0,        1'b1,1'b0,32'h0,       32'h55,       1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd10,1'b0,5'd9, 5'd10, 32'h0,        32'h0,        1'b1,1'b0,32'h0,       32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd9, 5'd10, 32'h0,        32'h0,        1'b1,1'b1,32'h0,       32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd4, 5'd10, 32'h55,       32'h0,        1'b0,1'b0,32'h0,       32'h55,       1'b0);
      // flush beats a same-cycle issue of rd=11
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd11,1'b1,5'd11,5'd9,  32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd11,5'd7,  32'h0,        32'h12345678, 1'b0,1'b0,32'h0,       32'h0,        1'b0);
      // dbg_reg shows x5 only after the write edge
      step(1'b0,1'b1,5'd5, 32'hCAFE,     1'b0,5'd0, 1'b0,5'd5, 5'd0,  32'hCAFE,     32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd5, 5'd0,  32'hCAFE,     32'h0,        1'b0,1'b0,32'hCAFE,    32'hCAFE,     1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd12,1'b0,5'd12,5'd0,  32'h0,        32'h0,        1'b0,1'b0,32'hCAFE,    32'h0,        1'b0);
      // issue to x0 is ignored
      step(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0, 1'b0,5'd12,5'd0,  32'h0,        32'h0,        1'b1,1'b0,32'hCAFE,    32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 5'd12, 32'h0,        32'h0,        1'b0,1'b1,32'hCAFE,    32'h0,        1'b0);
      // reset mid-operation beats a write and an issue on the same edge
      step(1'b1,1'b1,5'd6, 32'h77,       1'b1,5'd13,1'b0,5'd12,5'd5,  32'h0,        32'hCAFE,     1'b1,1'b0,32'hCAFE,    32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd12,5'd5,  32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd6, 5'd13, 32'h0,        32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      // set 20 and clear non-busy 21 together, then clear 20
      step(1'b0,1'b1,5'd21,32'h11,       1'b1,5'd20,1'b0,5'd21,5'd20, 32'h11,       32'h0,        1'b0,1'b0,32'h0,       32'h0,        1'b0);
      step(1'b0,1'b1,5'd20,32'h22,       1'b0,5'd0, 1'b0,5'd20,5'd21, 32'h22,       32'h11,       1'b0,1'b0,32'h0,       32'h0,        1'b1);
      step(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd20,5'd31, 32'h22,       32'h0,        1'b0,1'b0,32'h0,       32'h22,       1'b0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_regfile_sb
`default_nettype wire
